// File: rtl/inst_fetch_buffer_if.sv
// rtl/inst_fetch_buffer_if.sv - enqueue/dequeue bundle between IF, the fetch buffer and issue
interface inst_fetch_buffer_if #(
   parameter int DATA_W = 64,
   parameter int LANES  = 2
);
   localparam int DEQ_W = $clog2(LANES + 1);

   logic [LANES-1:0]        in_valid_i;
   logic [LANES*DATA_W-1:0] in_data_i;
   logic                    allowin_o;
   logic [LANES-1:0]        out_valid_o;
   logic [LANES*DATA_W-1:0] out_data_o;
   logic [DEQ_W-1:0]        deq_cnt_i;

   modport master (
      output in_valid_i, in_data_i, deq_cnt_i,
      input  allowin_o, out_valid_o, out_data_o
   );

   modport slave (
      input  in_valid_i, in_data_i, deq_cnt_i,
      output allowin_o, out_valid_o, out_data_o
   );
endinterface

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - LANES-wide circular instruction buffer between IF and ID
module inst_fetch_buffer #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8,
   parameter int LANES  = 2,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 branch_flush_i,
   input  logic                 excep_flush_i,
   inst_fetch_buffer_if.slave   bus,
   output logic [CNT_W-1:0]     count_o,
   output logic                 error_o
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic              error;

   logic              flush;
   logic              allowin;
   logic              prefix_ok;
   logic              err_cond;
   logic [CNT_W:0]    count_ext;
   logic [CNT_W:0]    deq_req;
   logic [CNT_W:0]    enq_n;
   logic [CNT_W:0]    deq_n;
   logic [CNT_W:0]    count_next;

   // Occupancy is tracked one bit wider so the defensive overflow check is meaningful.
   always_comb begin
      flush     = branch_flush_i | excep_flush_i;
      count_ext = {1'b0, count};
      allowin   = count_ext <= (CNT_W+1)'(DEPTH - LANES);
      deq_req   = (CNT_W+1)'(bus.deq_cnt_i);
      enq_n     = '0;
      prefix_ok = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         if (bus.in_valid_i[i]) enq_n = enq_n + (CNT_W+1)'(1);
      end
      for (int i = 1; i < LANES; i++) begin
         if (bus.in_valid_i[i] && !bus.in_valid_i[i-1]) prefix_ok = 1'b0;
      end
      if (!allowin) enq_n = '0;
      deq_n      = (deq_req > count_ext) ? count_ext : deq_req;
      count_next = count_ext + enq_n - deq_n;
      err_cond   = (deq_req > count_ext) || (!prefix_ok && allowin) ||
                   (count_ext > (CNT_W+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(deq_n);
         tail  <= tail + PTR_W'(enq_n);
         count <= CNT_W'(count_next);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)           error <= 1'b0;
      else if (err_cond) error <= 1'b1;
   end

   // Storage has no reset; validity is derived purely from count.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         for (int i = 0; i < LANES; i++) begin
            if ((CNT_W+1)'(i) < enq_n)
               mem[tail + PTR_W'(i)] <= bus.in_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      bus.out_data_o  = '0;
      bus.out_valid_o = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.out_data_o[i*DATA_W +: DATA_W] = mem[head + PTR_W'(i)];
         bus.out_valid_o[i]                 = count_ext > (CNT_W+1)'(i);
      end
   end

   assign bus.allowin_o = allowin;
   assign count_o       = count;
   assign error_o       = error;
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - randomized and directed bench for inst_fetch_buffer
module tb_inst_fetch_buffer;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 8;
   localparam int LANES  = 2;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int DEQ_W  = $clog2(LANES + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             branch_flush;
   logic             excep_flush;
   logic [CNT_W-1:0] count;
   logic             error;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_W-1:0] q[$];
   bit                m_err;

   inst_fetch_buffer_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

   inst_fetch_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
      .clk            (clk),
      .rst            (rst),
      .branch_flush_i (branch_flush),
      .excep_flush_i  (excep_flush),
      .bus            (bus),
      .count_o        (count),
      .error_o        (error)
   );

   always #5 clk = ~clk;

   function automatic logic [LANES*DATA_W-1:0] pack(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return {b, a};
   endfunction

   function automatic logic [DATA_W-1:0] val(input int k);
      return 64'hF00D_0000_0000_0000 | DATA_W'(k);
   endfunction

   // Drive one cycle, advance the queue model by the buffer's rules, and return #1 after the edge.
   task automatic cycle(input bit r, input bit bf, input bit ef, input logic [LANES-1:0] v,
                        input logic [LANES*DATA_W-1:0] d, input int deq);
      int  sz;
      int  pc;
      bit  allow;
      bit  prefix;
      rst            = r;
      branch_flush   = bf;
      excep_flush    = ef;
      bus.in_valid_i = v;
      bus.in_data_i  = d;
      bus.deq_cnt_i  = DEQ_W'(deq);
      if (r) begin
         q.delete();
         m_err = 0;
      end else begin
         sz     = q.size();
         allow  = (sz <= DEPTH - LANES);
         prefix = 1;
         pc     = 0;
         for (int i = 0; i < LANES; i++) if (v[i]) pc++;
         for (int i = 1; i < LANES; i++) if (v[i] && !v[i-1]) prefix = 0;
         if (deq > sz || (!prefix && allow)) m_err = 1;
         if (bf || ef) begin
            q.delete();
         end else begin
            for (int i = 0; i < deq && i < sz; i++) void'(q.pop_front());
            if (allow) for (int i = 0; i < pc; i++) q.push_back(d[i*DATA_W +: DATA_W]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 0, 0, '0, '0, 0);
      cycle(0, 0, 0, '0, '0, 0);
      tests_run++;
      if (bus.allowin_o !== 1'b1) begin tests_failed++; $display("FAIL reset_allowin: got %b expected 1", bus.allowin_o); end
      tests_run++;
      if (bus.out_valid_o !== 2'b00) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 00", bus.out_valid_o); end
      tests_run++;
      if (count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
      tests_run++;
      if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b expected 0", error); end
   endtask

   task automatic test_fill();
      int exp_cnt;
      cycle(1, 0, 0, '0, '0, 0);
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (bus.allowin_o !== 1'b1) begin tests_failed++; $display("FAIL fill_allowin_before_push%0d: got %b expected 1", k, bus.allowin_o); end
         cycle(0, 0, 0, 2'b11, pack(val(2*k), val(2*k+1)), 0);
         exp_cnt = 2 * (k + 1);
         tests_run++;
         if (count !== CNT_W'(exp_cnt)) begin tests_failed++; $display("FAIL fill_count%0d: got %0d expected %0d", k, count, exp_cnt); end
      end
      tests_run++;
      if (bus.allowin_o !== 1'b0) begin tests_failed++; $display("FAIL fill_allowin_full: got %b expected 0", bus.allowin_o); end
      cycle(0, 0, 0, 2'b11, pack(val(8), val(9)), 0);
      tests_run++;
      if (count !== CNT_W'(8)) begin tests_failed++; $display("FAIL fill_fifth_push: got %0d expected 8", count); end
      tests_run++;
      if (bus.out_data_o !== pack(val(0), val(1))) begin tests_failed++; $display("FAIL fill_out_data: got %h expected %h", bus.out_data_o, pack(val(0), val(1))); end
   endtask

   task automatic test_push_pop_full();
      cycle(0, 0, 0, 2'b00, '0, 1);
      tests_run++;
      if (count !== CNT_W'(7) || bus.allowin_o !== 1'b0) begin tests_failed++; $display("FAIL pp_count7: got count %0d allowin %b expected 7 0", count, bus.allowin_o); end
      cycle(0, 0, 0, 2'b11, pack(val(20), val(21)), 2);
      tests_run++;
      if (count !== CNT_W'(5)) begin tests_failed++; $display("FAIL pp_count5: got %0d expected 5", count); end
      tests_run++;
      if (bus.out_data_o !== pack(val(3), val(4))) begin tests_failed++; $display("FAIL pp_out_data: got %h expected %h", bus.out_data_o, pack(val(3), val(4))); end
   endtask

   task automatic test_wrap();
      cycle(1, 0, 0, '0, '0, 0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 2'b11, pack(val(30+2*k), val(31+2*k)), 0);
      cycle(0, 0, 0, 2'b01, pack(val(36), val(37)), 0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 2'b00, '0, 2);
      cycle(0, 0, 0, 2'b00, '0, 1);
      tests_run++;
      if (count !== '0) begin tests_failed++; $display("FAIL wrap_drained: got %0d expected 0", count); end
      cycle(0, 0, 0, 2'b11, pack(val(88), val(89)), 0);
      tests_run++;
      if (bus.out_valid_o !== 2'b11 || bus.out_data_o !== pack(val(88), val(89))) begin
         tests_failed++; $display("FAIL wrap_xy: got valid %b data %h expected 11 %h", bus.out_valid_o, bus.out_data_o, pack(val(88), val(89)));
      end
      cycle(0, 0, 0, 2'b00, '0, 1);
      tests_run++;
      if (count !== CNT_W'(1) || bus.out_data_o[DATA_W-1:0] !== val(89)) begin
         tests_failed++; $display("FAIL wrap_pop1: got count %0d lane0 %h expected 1 %h", count, bus.out_data_o[DATA_W-1:0], val(89));
      end
   endtask

   task automatic test_flush();
      cycle(1, 0, 0, '0, '0, 0);
      cycle(0, 0, 0, 2'b11, pack(val(40), val(41)), 0);
      cycle(0, 0, 0, 2'b11, pack(val(42), val(43)), 0);
      cycle(0, 0, 0, 2'b01, pack(val(44), val(45)), 0);
      cycle(0, 1, 0, 2'b11, pack(val(46), val(47)), 0);
      tests_run++;
      if (count !== '0 || bus.out_valid_o !== 2'b00 || bus.allowin_o !== 1'b1) begin
         tests_failed++; $display("FAIL flush_empty: got count %0d valid %b allowin %b expected 0 00 1", count, bus.out_valid_o, bus.allowin_o);
      end
      cycle(0, 0, 0, 2'b11, pack(val(50), val(51)), 0);
      tests_run++;
      if (bus.out_data_o[DATA_W-1:0] !== val(50)) begin tests_failed++; $display("FAIL flush_refill: got %h expected %h", bus.out_data_o[DATA_W-1:0], val(50)); end
   endtask

   task automatic test_random();
      int sz;
      int k;
      int deq;
      logic [LANES-1:0]        v;
      logic [LANES*DATA_W-1:0] d;
      logic [LANES-1:0]        exp_valid;
      cycle(1, 0, 0, '0, '0, 0);
      for (int n = 0; n < 400; n++) begin
         sz  = q.size();
         k   = $urandom_range(0, LANES);
         v   = LANES'((1 << k) - 1);
         d   = {$urandom, $urandom, $urandom, $urandom};
         deq = $urandom_range(0, (sz < LANES) ? sz : LANES);
         cycle(0, ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0), v, d, deq);
         sz = q.size();
         tests_run++;
         if (count !== CNT_W'(sz)) begin tests_failed++; $display("FAIL rand_count@%0d: got %0d expected %0d", n, count, sz); end
         tests_run++;
         if (bus.allowin_o !== (sz <= DEPTH - LANES)) begin tests_failed++; $display("FAIL rand_allowin@%0d: got %b expected %b", n, bus.allowin_o, sz <= DEPTH - LANES); end
         for (int i = 0; i < LANES; i++) exp_valid[i] = (sz > i);
         tests_run++;
         if (bus.out_valid_o !== exp_valid) begin tests_failed++; $display("FAIL rand_valid@%0d: got %b expected %b", n, bus.out_valid_o, exp_valid); end
         for (int i = 0; i < LANES; i++) begin
            if (i < sz) begin
               tests_run++;
               if (bus.out_data_o[i*DATA_W +: DATA_W] !== q[i]) begin
                  tests_failed++; $display("FAIL rand_data@%0d lane%0d: got %h expected %h", n, i, bus.out_data_o[i*DATA_W +: DATA_W], q[i]);
               end
            end
         end
         tests_run++;
         if (error !== m_err) begin tests_failed++; $display("FAIL rand_error@%0d: got %b expected %b", n, error, m_err); end
      end
   endtask

   task automatic test_errors();
      cycle(1, 0, 0, '0, '0, 0);
      cycle(0, 0, 0, 2'b01, pack(val(60), val(61)), 0);
      cycle(0, 0, 0, 2'b00, '0, 2);
      tests_run++;
      if (error !== 1'b1 || count !== '0) begin tests_failed++; $display("FAIL err_overdeq: got error %b count %0d expected 1 0", error, count); end
      cycle(1, 0, 0, '0, '0, 0);
      tests_run++;
      if (error !== 1'b0) begin tests_failed++; $display("FAIL err_rst_clear1: got %b expected 0", error); end
      cycle(0, 0, 0, 2'b10, pack(val(62), val(63)), 0);
      tests_run++;
      if (error !== m_err || error !== 1'b1) begin tests_failed++; $display("FAIL err_nonprefix: got %b expected 1", error); end
      cycle(0, 0, 1, 2'b00, '0, 0);
      tests_run++;
      if (error !== 1'b1 || count !== '0) begin tests_failed++; $display("FAIL err_flush_keeps: got error %b count %0d expected 1 0", error, count); end
      cycle(1, 0, 0, '0, '0, 0);
      tests_run++;
      if (error !== 1'b0) begin tests_failed++; $display("FAIL err_rst_clear2: got %b expected 0", error); end
   endtask

   initial begin
      rst            = 1'b1;
      branch_flush   = 1'b0;
      excep_flush    = 1'b0;
      bus.in_valid_i = '0;
      bus.in_data_i  = '0;
      bus.deq_cnt_i  = '0;
      m_err          = 0;
      test_reset();
      test_fill();
      test_push_pop_full();
      test_wrap();
      test_flush();
      test_random();
      test_errors();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Parametrised circular instruction buffer between the IF and ID stages.
- Generalises the dual-issue fetch queue:
  - LANES-wide enqueue and dequeue, parametric depth.
  - Exact occupancy tracking.
  - Per-lane dequeue count.
  - Sticky protocol-error detection.
- IF pushes up to LANES decoded-bundle slots per cycle; the issue logic pops 0..LANES per cycle.
- Branch and exception flushes empty the buffer.

Parameters:
- DATA_W, 64, payload width of one instruction slot.
- DEPTH, 8, number of entries; power of two, DEPTH >= 2*LANES.
- LANES, 2, max enqueue and max dequeue per cycle; 1..4.
- PTR_W, clog2(DEPTH), pointer width (derived).
- CNT_W, clog2(DEPTH+1), occupancy width (derived).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- branch_flush_i  in  1  discard all contents.
- excep_flush_i  in  1  discard all contents; same effect as branch_flush_i.
- in_valid_i  in  LANES  per-lane enqueue valid; must be a prefix mask (bit i set implies bit i-1 set).
- in_data_i  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- allowin_o  out  1  buffer can accept a full LANES-wide push this cycle.
- out_valid_o  out  LANES  lane i valid when occupancy > i.
- out_data_o  out  LANES*DATA_W  lane i = entry at (head+i) mod DEPTH.
- deq_cnt_i  in  clog2(LANES+1)  number of output lanes consumed this cycle.
- count_o  out  CNT_W  current occupancy.
- error_o  out  1  sticky protocol error.

Behaviour:
- Storage, pointers and count:
  - head (read pointer) and tail (write pointer), each PTR_W, wrap modulo DEPTH naturally.
  - count register is authoritative for full/empty; no pointer comparison.
- Enqueue:
  - enq_n = popcount(in_valid_i) when allowin_o is 1, else 0.
  - Lane i is written to mem[(tail+i) mod DEPTH] for i < enq_n.
  - tail advances by enq_n.
  - Data on non-valid lanes is ignored.
- allowin_o = (count <= DEPTH-LANES):
  - Combinational from the registered count only; independent of deq_cnt_i and in_valid_i.
  - No combinational path from inputs to allowin_o.
- Dequeue:
  - deq_n = min(deq_cnt_i, count).
  - head advances by deq_n.
  - Popped entries are not cleared; validity derives from count.
- Count update: count_next = count + enq_n - deq_n. Compute in CNT_W+1 bits; the result never exceeds DEPTH.
- Outputs:
  - out_valid_o[i] = (count > i).
  - out_data_o is a combinational read of mem at head+i.
  - Write-to-output latency is 1 cycle: an entry pushed in cycle t is visible in cycle t+1.
  - No same-cycle bypass.
- Simultaneous enqueue and dequeue are legal in the same cycle, including when count == DEPTH-LANES.
- Flush (either flush input):
  - Next cycle: head=0, tail=0, count=0.
  - Same-cycle enqueue and dequeue are dropped.
  - Flush has priority over everything except rst.
- Reset, including mid-operation:
  - head=0, tail=0, count=0, error_o=0.
  - Therefore allowin_o=1, out_valid_o=0, count_o=0.
  - mem contents are don't-care; out_data_o is don't-care while invalid.
- error_o is set (sticky) on the next edge when any of the following occurs:
  - deq_cnt_i > count;
  - in_valid_i is not a prefix mask while allowin_o is 1;
  - count > DEPTH (defensive).
- error_o is cleared only by rst. Flush does not clear it.
- On a deq_cnt_i error, the dequeue is still clamped as above.
- Wrap-around: pointer arithmetic is modulo DEPTH at every lane offset. Lane i of a push or pop may wrap while lane i-1 does not.

Test Plan:
- Reset then idle, LANES=2, DEPTH=8 -> allowin_o=1, out_valid_o=00, count_o=0, error_o=0.
- Four cycles pushing in_valid_i=11 with data A..H, deq_cnt_i=0:
  - count_o goes 2,4,6,8.
  - allowin_o=0 once count_o=8; allowin_o was still 1 at count_o=6.
  - A 5th push is ignored: count_o stays 8.
  - out_data_o lanes = A,B.
- With count=7, push 11 and deq_cnt_i=2 in the same cycle -> push is dropped (allowin_o=0), count_o=5, outputs show the third and fourth oldest entries.
- Wrap: after head=tail=7 with count=0, push X,Y:
  - next cycle out_data_o lanes = X (mem[7]), Y (mem[0]), out_valid_o=11.
  - deq_cnt_i=1 -> Y moves to lane 0, count_o=1.
- count=5, push 11 with branch_flush_i=1 -> next cycle count_o=0, out_valid_o=00, allowin_o=1; a following push of P,Q shows P at lane 0.
- Protocol errors:
  - count=1 with deq_cnt_i=2 -> error_o=1 next cycle, count_o=0.
  - in_valid_i=10 -> error_o=1.
  - Flush leaves error_o=1; rst clears it.
